// File: rtl/mem_merge_sequencer_pkg.sv
// Shared defaults and state encoding for the merge-stage read sequencer.
package mem_merge_sequencer_pkg;

  localparam int unsigned NMEM_DEF      = 12;
  localparam int unsigned NENT_W_DEF    = 6;
  localparam int unsigned SEL_W_DEF     = 4;
  localparam int unsigned RD_LAT_DEF    = 2;
  localparam int unsigned MAX_READS_DEF = 108;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

endpackage

// File: rtl/mem_merge_sequencer_first_set_index.sv
// Combinational lowest-set-bit finder: idx is the lowest set position of vec, any = |vec.
module first_set_index #(
  parameter int unsigned N     = 12,
  parameter int unsigned SEL_W = 4
) (
  input  logic [N-1:0]     vec,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int unsigned i = N; i > 0; i--) begin
      if (vec[i-1]) idx = SEL_W'(i - 1);
    end
    any = |vec;
  end

endmodule

// File: rtl/mem_merge_sequencer.sv
// Walks the non-empty input memory blocks in priority order, one read per stored entry,
// with a per-event read budget and an RD_LAT-delayed copy of the read strobe for the merge mux.
module mem_merge_sequencer
  import mem_merge_sequencer_pkg::*;
#(
  parameter int unsigned NMEM      = NMEM_DEF,
  parameter int unsigned NENT_W    = NENT_W_DEF,
  parameter int unsigned SEL_W     = SEL_W_DEF,
  parameter int unsigned RD_LAT    = RD_LAT_DEF,
  parameter int unsigned MAX_READS = MAX_READS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             bx_in,
  input  logic [NMEM*NENT_W-1:0] nent,
  output logic                   rd_en,
  output logic [SEL_W-1:0]       rd_sel,
  output logic [NENT_W-1:0]      rd_add,
  output logic [SEL_W-1:0]       mux_sel,
  output logic                   mux_valid,
  output logic [2:0]             bx_out,
  output logic                   done,
  output logic                   truncated
);

  localparam int unsigned RC_W = $clog2(MAX_READS + 1);

  state_e                            state_q, state_d;
  logic [NMEM-1:0]                   mask_q, mask_d, mask_new, mask_eff;
  logic [NMEM*NENT_W-1:0]            cnt_q, cnt_d, cnt_eff;
  logic [NENT_W-1:0]                 addr_q, addr_d, addr_eff, cur_cnt;
  logic [RC_W-1:0]                   rdcnt_q, rdcnt_d, rdcnt_eff;
  logic                              rd_en_q, rd_en_d, done_q, done_d, trunc_q, trunc_d;
  logic [SEL_W-1:0]                  rd_sel_q, rd_sel_d, cur;
  logic [NENT_W-1:0]                 rd_add_q, rd_add_d;
  logic [2:0]                        bx_q, bx_d;
  logic [RD_LAT-1:0][SEL_W:0]        pipe_q, pipe_d;
  logic                              any_set, active;

  // A start bypasses the registered mask/counts so the first read of the
  // new event is issued on the very edge that samples start.
  always_comb begin
    for (int unsigned i = 0; i < NMEM; i++) begin
      mask_new[i] = (nent[i*NENT_W +: NENT_W] != '0);
    end
    mask_eff  = start ? mask_new : mask_q;
    cnt_eff   = start ? nent : cnt_q;
    addr_eff  = start ? '0 : addr_q;
    rdcnt_eff = start ? '0 : rdcnt_q;
    active    = start || (state_q == ST_READ);
  end

  first_set_index #(.N(NMEM), .SEL_W(SEL_W)) u_fsi (
    .vec (mask_eff),
    .idx (cur),
    .any (any_set)
  );

  always_comb begin
    cur_cnt = '0;
    for (int unsigned i = 0; i < NMEM; i++) begin
      if (SEL_W'(i) == cur) cur_cnt = cnt_eff[i*NENT_W +: NENT_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    rdcnt_d  = rdcnt_q;
    cnt_d    = cnt_eff;
    bx_d     = start ? bx_in : bx_q;
    rd_en_d  = 1'b0;
    rd_sel_d = rd_sel_q;
    rd_add_d = rd_add_q;
    done_d   = 1'b0;
    trunc_d  = start ? 1'b0 : trunc_q;

    if (active) begin
      if (!any_set) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        mask_d  = '0;
      end else if (rdcnt_eff == RC_W'(MAX_READS)) begin
        done_d  = 1'b1;
        trunc_d = 1'b1;
        state_d = ST_IDLE;
        mask_d  = '0;
      end else begin
        rd_en_d  = 1'b1;
        rd_sel_d = cur;
        rd_add_d = addr_eff;
        rdcnt_d  = rdcnt_eff + RC_W'(1);
        state_d  = ST_READ;
        mask_d   = mask_eff;
        if (addr_eff == cur_cnt - NENT_W'(1)) begin
          for (int unsigned i = 0; i < NMEM; i++) begin
            if (SEL_W'(i) == cur) mask_d[i] = 1'b0;
          end
          addr_d = '0;
        end else begin
          addr_d = addr_eff + NENT_W'(1);
        end
      end
    end
  end

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {rd_en_q, rd_sel_q};
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      rdcnt_q  <= '0;
      rd_en_q  <= 1'b0;
      rd_sel_q <= '0;
      rd_add_q <= '0;
      done_q   <= 1'b0;
      trunc_q  <= 1'b0;
      bx_q     <= '0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rdcnt_q  <= rdcnt_d;
      rd_en_q  <= rd_en_d;
      rd_sel_q <= rd_sel_d;
      rd_add_q <= rd_add_d;
      done_q   <= done_d;
      trunc_q  <= trunc_d;
      bx_q     <= bx_d;
      pipe_q   <= pipe_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_sel    = rd_sel_q;
  assign rd_add    = rd_add_q;
  assign done      = done_q;
  assign truncated = trunc_q;
  assign bx_out    = bx_q;
  assign mux_valid = pipe_q[RD_LAT-1][SEL_W];
  assign mux_sel   = pipe_q[RD_LAT-1][SEL_W-1:0];

endmodule
